// File: rtl/multi_valve_fsm.sv
// multi_valve_fsm: N-channel valve controller with bounded concurrency,
// sticky round-robin arbitration, empty-tank demotion and latched faults.
module multi_valve_fsm #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned MAX_ON  = 2,
    parameter int unsigned RUN_MAX = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*N_CH-1:0]   g,
    input  logic [1:0]          lvl,
    input  logic                lvl_fault,
    input  logic                err_clr,
    output logic [2*N_CH-1:0]   r,
    output logic [1:0]          e,
    output logic [N_CH-1:0]     grant,
    output logic                busy
);

    localparam int unsigned CW = $clog2(RUN_MAX + 1);
    localparam int unsigned PW = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic [CW-1:0]       cnt   [N_CH];
    logic [CW-1:0]       cnt_n [N_CH];
    logic [2*N_CH-1:0]   r_n;
    logic [1:0]          e_n;
    logic [N_CH-1:0]     grant_n;
    logic                busy_n;

    logic                fc;
    logic                timeout;
    logic [N_CH-1:0]     req;
    logic [N_CH-1:0]     keep;
    logic [N_CH-1:0]     new_grant;
    logic [N_CH-1:0]     arb_grant;
    logic [PW-1:0]       arb_ptr;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       last;
    logic                found;
    int unsigned         kept;
    int unsigned         slots;
    logic                load;
    logic                demote;
    logic [1:0]          code;

    // Per-channel request flags, fault condition and run-time limit detect
    always_comb begin
        fc      = lvl_fault | (lvl == 2'b11);
        timeout = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            req[i] = |g[2*i +: 2];
            if (cnt[i] == CW'(RUN_MAX)) begin
                timeout = 1'b1;
            end
        end
    end

    // Sticky round-robin: keep live grants, fill free slots scanning from ptr
    always_comb begin
        keep      = grant & req;
        kept      = 0;
        new_grant = '0;
        found     = 1'b0;
        last      = ptr;
        idx       = ptr;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (keep[i]) begin
                kept = kept + 1;
            end
        end
        slots = MAX_ON - kept;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = PW'((32'(ptr) + k) % N_CH);
            if (req[idx] && !grant[idx] && (slots != 0)) begin
                new_grant[idx] = 1'b1;
                slots          = slots - 1;
                last           = idx;
                found          = 1'b1;
            end
        end
        arb_grant = keep | new_grant;
        arb_ptr   = found ? PW'((32'(last) + 1) % N_CH) : ptr;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = '0;
        r_n     = '0;
        e_n     = 2'b00;
        load    = 1'b0;
        demote  = 1'b0;
        code    = 2'b00;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_n[i] = '0;
        end

        case (state)
            IDLE: begin
                if (fc) begin
                    state_n = FAULT;
                    e_n     = 2'b10;
                    ptr_n   = '0;
                end else if (|req) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (fc) begin
                    state_n = FAULT;
                    e_n     = 2'b10;
                    ptr_n   = '0;
                end else if (timeout) begin
                    state_n = FAULT;
                    e_n     = 2'b11;
                    ptr_n   = '0;
                end else if (!(|req)) begin
                    state_n = IDLE;
                end else begin
                    load = 1'b1;
                end
            end
            FAULT: begin
                e_n = e;
                if (err_clr && !fc && !(|req)) begin
                    state_n = IDLE;
                    e_n     = 2'b00;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Drive granted channels, demoting full flow on an empty tank
        if (load) begin
            grant_n = arb_grant;
            ptr_n   = arb_ptr;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (arb_grant[i]) begin
                    code = g[2*i +: 2];
                    if ((lvl == 2'b00) && (code == 2'b11)) begin
                        code   = 2'b01;
                        demote = 1'b1;
                    end
                    r_n[2*i +: 2] = code;
                    cnt_n[i] = (cnt[i] == CW'(RUN_MAX)) ? cnt[i] : cnt[i] + CW'(1);
                end
            end
            e_n = demote ? 2'b01 : 2'b00;
        end

        busy_n = (state_n == RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            r     <= '0;
            e     <= 2'b00;
            busy  <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            grant <= grant_n;
            r     <= r_n;
            e     <= e_n;
            busy  <= busy_n;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_n[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_valve_fsm.sv
// tb_multi_valve_fsm: scoreboard bench for two multi_valve_fsm instances
// (MAX_ON=2 and MAX_ON=1, RUN_MAX=8) sharing one stimulus stream.
module tb_multi_valve_fsm;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    typedef struct packed {
        logic [1:0]      st;
        logic [1:0]      ptr;
        logic [3:0][3:0] cnt;
        logic [3:0]      grant;
        logic [7:0]      r;
        logic [1:0]      e;
    } mstate_t;

    typedef struct packed {
        logic [7:0] r_a;
        logic [1:0] e_a;
        logic [3:0] gr_a;
        logic       bz_a;
        logic [7:0] r_b;
        logic [1:0] e_b;
        logic [3:0] gr_b;
        logic       bz_b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] g;
    logic [1:0] lvl;
    logic       lvl_fault;
    logic       err_clr;
    logic [7:0] r_a, r_b;
    logic [1:0] e_a, e_b;
    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b;

    int      n_tests = 0;
    int      n_fail  = 0;
    mstate_t ma, mb;
    exp_t    sb[$];

    multi_valve_fsm #(.N_CH(4), .MAX_ON(2), .RUN_MAX(8)) dut_a (
        .clk(clk), .reset(reset), .g(g), .lvl(lvl), .lvl_fault(lvl_fault),
        .err_clr(err_clr), .r(r_a), .e(e_a), .grant(grant_a), .busy(busy_a)
    );

    multi_valve_fsm #(.N_CH(4), .MAX_ON(1), .RUN_MAX(8)) dut_b (
        .clk(clk), .reset(reset), .g(g), .lvl(lvl), .lvl_fault(lvl_fault),
        .err_clr(err_clr), .r(r_b), .e(e_b), .grant(grant_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: one clock of the controller for a given slot limit
    function automatic mstate_t model_next(mstate_t m, int max_on, logic [7:0] gg,
                                           logic [1:0] lv, logic lf, logic ec);
        mstate_t n;
        logic    fc;
        logic    to;
        logic    dem;
        logic [1:0] cd;
        int      held;
        int      c;
        int      j;
        fc = lf || (lv == 2'b11);
        n  = m;
        if (m.st == S_FAULT) begin
            if (ec && !fc && (gg == 8'h00)) begin
                n.st = S_IDLE;
                n.e  = 2'b00;
            end
            return n;
        end
        to = 1'b0;
        for (int i = 0; i < 4; i++) if (m.cnt[i] == 4'd8) to = 1'b1;
        if (fc || ((m.st == S_RUN) && to)) begin
            n    = '0;
            n.st = S_FAULT;
            n.e  = fc ? 2'b10 : 2'b11;
            return n;
        end
        if (gg == 8'h00) begin
            n.st    = S_IDLE;
            n.grant = '0;
            n.r     = '0;
            n.cnt   = '0;
            n.e     = 2'b00;
            return n;
        end
        n.st = S_RUN;
        for (int i = 0; i < 4; i++) if (gg[2*i +: 2] == 2'b00) n.grant[i] = 1'b0;
        held = $countones(n.grant);
        while (held < max_on) begin
            c = -1;
            for (int k = 0; k < 4; k++) begin
                j = (int'(n.ptr) + k) % 4;
                if ((c < 0) && (gg[2*j +: 2] != 2'b00) && !n.grant[j]) c = j;
            end
            if (c < 0) break;
            n.grant[c] = 1'b1;
            n.ptr      = 2'((c + 1) % 4);
            held++;
        end
        dem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (n.grant[i]) begin
                n.cnt[i] = (m.cnt[i] == 4'd8) ? 4'd8 : 4'(m.cnt[i] + 4'd1);
                cd = gg[2*i +: 2];
                if ((lv == 2'b00) && (cd == 2'b11)) begin
                    cd  = 2'b01;
                    dem = 1'b1;
                end
                n.r[2*i +: 2] = cd;
            end else begin
                n.cnt[i]      = 4'd0;
                n.r[2*i +: 2] = 2'b00;
            end
        end
        n.e = dem ? 2'b01 : 2'b00;
        return n;
    endfunction

    // Predict, push, clock, then pop and compare both instances
    task automatic step();
        exp_t x;
        ma = model_next(ma, 2, g, lvl, lvl_fault, err_clr);
        mb = model_next(mb, 1, g, lvl, lvl_fault, err_clr);
        x  = '{ma.r, ma.e, ma.grant, (ma.st == S_RUN), mb.r, mb.e, mb.grant, (mb.st == S_RUN)};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("r_a",     r_a,              x.r_a);
        check("e_a",     8'(e_a),          8'(x.e_a));
        check("grant_a", 8'(grant_a),      8'(x.gr_a));
        check("busy_a",  8'(busy_a),       8'(x.bz_a));
        check("r_b",     r_b,              x.r_b);
        check("e_b",     8'(e_b),          8'(x.e_b));
        check("grant_b", 8'(grant_b),      8'(x.gr_b));
        check("busy_b",  8'(busy_b),       8'(x.bz_b));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r_a"},  r_a, 8'h00);
        check({tag, "_e_a"},  8'(e_a), 8'h00);
        check({tag, "_gr_a"}, 8'(grant_a), 8'h00);
        check({tag, "_bz_a"}, 8'(busy_a), 8'h00);
        check({tag, "_r_b"},  r_b, 8'h00);
        check({tag, "_e_b"},  8'(e_b), 8'h00);
        check({tag, "_gr_b"}, 8'(grant_b), 8'h00);
        check({tag, "_bz_b"}, 8'(busy_b), 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        g         = 8'h00;
        lvl       = 2'b10;
        lvl_fault = 1'b0;
        err_clr   = 1'b0;
        ma        = '0;
        mb        = '0;
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Two slots, three requesters; ch0 drops and ch2 takes its slot
        g = 8'h39;
        step();
        check("t1_grant", 8'(grant_a), 8'h03);
        check("t1_r",     r_a,         8'h09);
        check("t1_busy",  8'(busy_a),  8'h01);
        repeat (4) step();
        g = 8'h38;
        step();
        check("t1_regrant", 8'(grant_a), 8'h06);
        check("t1_r_ch2",   r_a,         8'h38);
        g = 8'h34;
        step();
        check("t1_mode", r_a, 8'h34);

        // Asynchronous reset between edges while running
        #3;
        reset = 1'b1;
        g     = 8'h00;
        #1;
        check_zero("areset");
        ma = '0;
        mb = '0;
        #2;
        reset = 1'b0;

        // Re-raise all requests: pointer restarts at 0; then rotate holders
        g = 8'h55;
        step();
        check("rr_a0", 8'(grant_a), 8'h03);
        check("rr_b0", 8'(grant_b), 8'h01);
        g = 8'h54;
        step();
        check("rr_b1", 8'(grant_b), 8'h02);
        g = 8'h51;
        step();
        check("rr_b2", 8'(grant_b), 8'h04);
        g = 8'h45;
        step();
        check("rr_b3", 8'(grant_b), 8'h08);
        g = 8'h15;
        step();
        check("rr_b4", 8'(grant_b), 8'h01);
        g = 8'h00;
        step();

        // Empty tank demotes full flow, recovers when level returns
        g = 8'h0C;
        step();
        lvl = 2'b00;
        step();
        check("empty_r", r_a, 8'h04);
        check("empty_e", 8'(e_a), 8'h01);
        lvl = 2'b10;
        step();
        check("refill_r", r_a, 8'h0C);
        check("refill_e", 8'(e_a), 8'h00);

        // Sensor fault pulse, ignored clears, then a valid clear
        lvl_fault = 1'b1;
        step();
        check("lf_r",  r_a,          8'h00);
        check("lf_gr", 8'(grant_a),  8'h00);
        check("lf_e",  8'(e_a),      8'h02);
        lvl_fault = 1'b0;
        err_clr   = 1'b1;
        step();
        check("clr_busy_req", 8'(e_a), 8'h02);
        g   = 8'h00;
        lvl = 2'b11;
        step();
        check("clr_busy_fc", 8'(e_a), 8'h02);
        lvl = 2'b10;
        step();
        check("clr_ok", 8'(e_a), 8'h00);
        step();
        err_clr = 1'b0;

        // Run-time limit: ninth granted edge faults with timeout
        g = 8'h01;
        repeat (8) step();
        check("to_pre_busy", 8'(busy_a), 8'h01);
        step();
        check("to_e",  8'(e_a),     8'h03);
        check("to_gr", 8'(grant_a), 8'h00);
        g       = 8'h00;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Level fault wins over a same-cycle timeout
        g = 8'h01;
        repeat (8) step();
        lvl = 2'b11;
        step();
        check("to_vs_fc_e", 8'(e_a), 8'h02);
        lvl     = 2'b10;
        g       = 8'h00;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();

        // Random traffic against the scoreboard
        for (int n = 0; n < 300; n++) begin
            int unsigned pick;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) g[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) g = 8'h00;
            pick = $urandom_range(0, 19);
            lvl = (pick < 3) ? 2'b00 : (pick == 3) ? 2'b11 : (pick < 6) ? 2'b01 : 2'b10;
            lvl_fault = ($urandom_range(0, 39) == 0);
            err_clr   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
